// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional range checking is enabled in dmem_responder by defining DMEM_RANGE_ERR_EN.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_WSTRB_W = 4;
    localparam logic [DMEM_WSTRB_W-1:0] DMEM_WSTRB_LOAD = 4'b0000;

    // Replaces the byte lanes selected by wstrb; a load mask returns old_word unchanged.
    function automatic logic [31:0] dmem_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [DMEM_WSTRB_W-1:0] wstrb);
        logic [31:0] r;
        r = old_word;
        for (int unsigned i = 0; i < DMEM_WSTRB_W; i++) begin
            if (wstrb[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with byte-lane-masked synchronous write.
// merged is the post-write view of the addressed word (equal to the stored word for loads).
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [DEPTH_LOG2-1:0]   idx,
    input  logic [DMEM_WSTRB_W-1:0] wstrb,
    input  logic [31:0]             wdata,
    output logic [31:0]             merged
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    assign merged = dmem_merge(mem[idx], wdata, wstrb);

    always_ff @(posedge clk) begin
        if (en && (wstrb != DMEM_WSTRB_LOAD)) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder with WAIT_CYCLES wait states and a pipeline stall request.
// Define DMEM_RANGE_ERR_EN to add resp_err and reject addresses beyond the array.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DMEM_WSTRB_W-1:0] req_wstrb,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    stall_req
`ifdef DMEM_RANGE_ERR_EN
    ,
    output logic                    resp_err
`endif
);

    dmem_state_t              state;
    logic [3:0]               cnt;
    logic [DEPTH_LOG2-1:0]    idx_q;
    logic [DMEM_WSTRB_W-1:0]  wstrb_q;
    logic [31:0]              wdata_q;
    logic                     oor_q;

    logic                     is_idle;
    logic                     oor_live;
    logic [DEPTH_LOG2-1:0]    sel_idx;
    logic [DMEM_WSTRB_W-1:0]  sel_wstrb;
    logic [31:0]              sel_wdata;
    logic                     sel_oor;
    logic                     commit;
    logic [31:0]              bank_merged;
    logic [31:0]              resp_word;
    logic                     unused_addr;

    assign unused_addr = &{1'b0, req_addr[1:0], req_addr[31:DEPTH_LOG2+2]};

`ifdef DMEM_RANGE_ERR_EN
    assign oor_live = (req_addr >> (DEPTH_LOG2 + 2)) != '0;
`else
    assign oor_live = 1'b0;
`endif

    // With zero wait states the commit edge is the acceptance edge, so the live request feeds the bank.
    assign is_idle   = (state == DMEM_IDLE);
    assign sel_idx   = is_idle ? req_addr[DEPTH_LOG2+1:2] : idx_q;
    assign sel_wstrb = is_idle ? req_wstrb : wstrb_q;
    assign sel_wdata = is_idle ? req_wdata : wdata_q;
    assign sel_oor   = is_idle ? oor_live : oor_q;

    assign commit = (is_idle && req_valid && (WAIT_CYCLES == 0))
                  || ((state == DMEM_WAIT) && (cnt == '0));

    assign resp_word = sel_oor ? '0 : bank_merged;
    assign stall_req = (is_idle && req_valid) || (state == DMEM_WAIT);

    dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk    (clk),
        .en     (commit && !sel_oor && reset),
        .idx    (sel_idx),
        .wstrb  (sel_wstrb),
        .wdata  (sel_wdata),
        .merged (bank_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DMEM_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            oor_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef DMEM_RANGE_ERR_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (commit) begin
                resp_valid <= 1'b1;
                resp_rdata <= resp_word;
`ifdef DMEM_RANGE_ERR_EN
                resp_err   <= sel_oor;
`endif
            end
            case (state)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        idx_q     <= req_addr[DEPTH_LOG2+1:2];
                        wstrb_q   <= req_wstrb;
                        wdata_q   <= req_wdata;
                        oor_q     <= oor_live;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= DMEM_RESP;
                        end else begin
                            state <= DMEM_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (cnt == '0) begin
                        state <= DMEM_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DMEM_RESP: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
// Build with DMEM_RANGE_ERR_EN defined to exercise resp_err.
module tb_dmem_responder;

    localparam int W = 2;
    localparam int D = 10;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall_req;

    logic        v0;
    logic        ready0;
    logic [3:0]  s0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        rv0;
    logic [31:0] rd0;
    logic        stall0;

`ifdef DMEM_RANGE_ERR_EN
    logic        resp_err;
    logic        resp_err0;
`endif

    int          total;
    int          bad;
    int          cyc;
    exp_t        sb[$];
    logic [31:0] mem_m [0:1023];

    dmem_responder #(
        .DEPTH_LOG2  (D),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wstrb  (req_wstrb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .stall_req  (stall_req)
`ifdef DMEM_RANGE_ERR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    dmem_responder #(
        .DEPTH_LOG2  (D),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (v0),
        .req_ready  (ready0),
        .req_wstrb  (s0),
        .req_addr   (a0),
        .req_wdata  (d0),
        .resp_valid (rv0),
        .resp_rdata (rd0),
        .stall_req  (stall0)
`ifdef DMEM_RANGE_ERR_EN
        ,
        .resp_err   (resp_err0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: got rdata=%h at cyc %0d, want no response", resp_rdata, cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (resp_rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL resp_rdata: got %h want %h", resp_rdata, e.rdata);
                end
                total++;
                if (cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL resp_latency: got cyc %0d want cyc %0d", cyc, e.cyc);
                end
`ifdef DMEM_RANGE_ERR_EN
                total++;
                if (resp_err !== e.err) begin
                    bad++;
                    $display("FAIL resp_err: got %b want %b", resp_err, e.err);
                end
`endif
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL resp_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit chk);
        int          t;
        int          n;
        logic [31:0] nw;
        logic        oor;
        exp_t        e;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL ready_timeout: got req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_wstrb = s;
        req_wdata = d;
        n = cyc;
`ifdef DMEM_RANGE_ERR_EN
        oor = |a[31:D+2];
`else
        oor = 1'b0;
`endif
        nw = lane_merge(mem_m[a[D+1:2]], d, s);
        if (oor) nw = 32'h0;
        else if (s != 4'b0000) mem_m[a[D+1:2]] = nw;
        e.rdata = nw;
        e.cyc   = n + W + 1;
        e.err   = oor;
        sb.push_back(e);
        #1;
        total++;
        if (stall_req !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept: got %b want 1", stall_req);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        if (chk) begin
            for (int k = 1; k <= W + 1; k++) begin
                total++;
                if (stall_req !== (k <= W)) begin
                    bad++;
                    $display("FAIL stall_busy: got %b want %b (k=%0d)", stall_req, (k <= W), k);
                end
                total++;
                if (req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_busy: got %b want 0 (k=%0d)", req_ready, k);
                end
                @(negedge clk);
            end
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_wstrb = '0; req_addr = '0; req_wdata = '0;
        v0 = 1'b0; s0 = '0; a0 = '0; d0 = '0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        access(32'h10, 4'b1111, 32'hDEADBEEF, 1'b1);
        access(32'h10, 4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_byte_lane();
        access(32'h20, 4'b1111, 32'h11223344, 1'b0);
        access(32'h20, 4'b0010, 32'h0000AA00, 1'b1);
        access(32'h20, 4'b0000, 32'h0, 1'b0);
    endtask

    task automatic test_wrap_or_range();
`ifdef DMEM_RANGE_ERR_EN
        access(32'h0000_1004, 4'b0000, 32'h0, 1'b1);
        access(32'h0000_1010, 4'b1111, 32'hFFFF_FFFF, 1'b0);
        access(32'h10, 4'b0000, 32'h0, 1'b0);
`else
        access(32'h0000_1004, 4'b1111, 32'h12345678, 1'b0);
        access(32'h0000_0004, 4'b0000, 32'h0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_wait();
        access(32'h40, 4'b1111, 32'h0BADC0DE, 1'b0);
        req_valid = 1'b1; req_addr = 32'h40; req_wstrb = 4'b1111; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL abort_stall: got %b want 0", stall_req); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", resp_valid); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        access(32'h40, 4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        req_valid = 1'b1; req_addr = 32'h10; req_wstrb = 4'b0000; req_wdata = 32'h0;
        for (int j = 0; j < 3 * (W + 2); j++) begin
            if (j % (W + 2) == 0) begin
                e.rdata = mem_m[4]; e.cyc = cyc + W + 1; e.err = 1'b0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) access(32'h100 + 32'(4 * i), 4'b1111, $urandom, 1'b0);
        for (int i = 0; i < 24; i++) begin
            access(32'h100 + 32'(4 * $urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom, 1'b1);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] pat;
        pat = 32'h55AA1234;
        for (int p = 0; p < 2; p++) begin
            v0 = 1'b1; a0 = 32'h8; s0 = (p == 0) ? 4'b1111 : 4'b0000; d0 = (p == 0) ? pat : 32'h0;
            #1;
            total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL w0_stall_n: got %b want 1", stall0); end
            total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL w0_ready_n: got %b want 1", ready0); end
            @(negedge clk);
            v0 = 1'b0; d0 = $urandom;
            #1;
            total++; if (rv0 !== 1'b1) begin bad++; $display("FAIL w0_valid: got %b want 1", rv0); end
            total++; if (rd0 !== pat) begin bad++; $display("FAIL w0_rdata: got %h want %h", rd0, pat); end
            total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL w0_ready_n1: got %b want 0", ready0); end
            total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL w0_stall_n1: got %b want 0", stall0); end
            @(negedge clk);
            total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL w0_ready_n2: got %b want 1", ready0); end
            total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL w0_valid_n2: got %b want 0", rv0); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_wrap_or_range();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        test_zero_wait();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
